// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM ramp scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int DUTY_MAX   = 100;
  localparam int PWM_PERIOD = 101;

  typedef logic [31:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Clamp a requested duty to the channel ceiling.
  function automatic duty_t sat_duty(input duty_t d, input duty_t max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command write port of the ramp scheduler (target duty + ramp step per channel).
// Latency: a write lands in the target/step registers on the next clock edge.
// Backpressure: none; the slave accepts a write every cycle.
interface pwm_ramp_ctrl_if #(
  parameter int NCH = 4
);
  import pwm_pkg::*;

  localparam int CW = $clog2(NCH);

  logic          wr_en;
  logic [CW-1:0] wr_ch;
  duty_t         wr_duty;
  logic [7:0]    wr_step;

  modport master (output wr_en, wr_ch, wr_duty, wr_step);
  modport slave  (input  wr_en, wr_ch, wr_duty, wr_step);

endinterface

// File: rtl/pwm_tick_gen.sv
// Free-running period counter producing a one-cycle tick at count PERIOD-1.
// Latency: first tick is sampled PERIOD clocks after reset release.
// Backpressure: none; the tick is a free-running pulse.
module pwm_tick_gen #(
  parameter int PERIOD = 101
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count;

  // Count 0..PERIOD-1 and wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (count == CW'(PERIOD - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == CW'(PERIOD - 1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Per-period duty scheduler: ramps each channel's current duty toward its target, one channel per cycle after tick.
// Latency: channel k strobed k+1 clocks after the tick edge; busy/irq follow duty changes by one clock.
// Backpressure: none; writes accepted every cycle. Optional completion irq under PWM_RAMP_IRQ_EN.
module pwm_ramp_ctrl #(
  parameter int NCH      = 4,
  parameter int PERIOD   = pwm_pkg::PWM_PERIOD,
  parameter int DUTY_MAX = pwm_pkg::DUTY_MAX
) (
  input  logic              clock,
  input  logic              resetn,
  pwm_ramp_ctrl_if.slave    wr,
  output logic [NCH*32-1:0] duty_out,
  output logic [NCH-1:0]    atualiza_out,
  output logic [NCH-1:0]    busy,
  output logic              irq
);

  import pwm_pkg::*;

  localparam int CW = $clog2(NCH);

  duty_t         target [NCH];
  duty_t         cur    [NCH];
  logic [7:0]    step   [NCH];

  state_t        state;
  logic [CW-1:0] ch;
  logic          tick;

  duty_t         cur_s;
  duty_t         tgt_s;
  duty_t         stp_s;
  duty_t         diff;
  duty_t         nxt;
  logic          up;
  logic [NCH-1:0] busy_nxt;

  pwm_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick)
  );

  // Latch target (saturated) and step for the addressed channel; out-of-range channels are dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NCH; k++) begin
        target[k] <= '0;
        step[k]   <= '0;
      end
    end else if (wr.wr_en && (int'(wr.wr_ch) < NCH)) begin
      target[wr.wr_ch] <= sat_duty(wr.wr_duty, duty_t'(DUTY_MAX));
      step[wr.wr_ch]   <= wr.wr_step;
    end
  end

  // Next duty for the channel under service; compare first so the subtraction never wraps.
  always_comb begin
    cur_s = cur[ch];
    tgt_s = target[ch];
    stp_s = duty_t'(step[ch]);
    up    = 1'b0;
    diff  = '0;
    nxt   = cur_s;
    if (tgt_s > cur_s) begin
      up   = 1'b1;
      diff = tgt_s - cur_s;
    end else begin
      diff = cur_s - tgt_s;
    end
    if ((stp_s == '0) || (diff <= stp_s)) begin
      nxt = tgt_s;
    end else if (up) begin
      nxt = cur_s + stp_s;
    end else begin
      nxt = cur_s - stp_s;
    end
  end

  // Scheduler FSM: wait for tick, then service channels 0..NCH-1 one per cycle with a registered strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      ch           <= '0;
      atualiza_out <= '0;
      for (int k = 0; k < NCH; k++) begin
        cur[k] <= '0;
      end
    end else begin
      atualiza_out <= '0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            ch    <= '0;
          end
        end
        SCAN: begin
          if (cur[ch] != target[ch]) begin
            cur[ch]          <= nxt;
            atualiza_out[ch] <= 1'b1;
          end
          if (ch == CW'(NCH - 1)) begin
            state <= IDLE;
            ch    <= '0;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          ch    <= '0;
        end
      endcase
    end
  end

  // Flatten current duties onto the output bus.
  always_comb begin
    duty_out = '0;
    for (int k = 0; k < NCH; k++) begin
      duty_out[32*k +: 32] = cur[k];
    end
  end

  // Channel still has distance to cover.
  always_comb begin
    busy_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      busy_nxt[k] = (cur[k] != target[k]);
    end
  end

  // Register busy so it trails target/current changes by one clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

`ifdef PWM_RAMP_IRQ_EN
  // Pulse when any channel goes from busy to settled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(busy & ~busy_nxt);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
